fft_bin_write_seq: RTL and testbench
====================================

# fft_bin_write_seq

Write sequencer between the FFT core's output stream and the spectrogram-RAM address mapper. It accepts one FFT frame at a time, keeps the lower half-spectrum bins, and emits a registered write strobe with data, 7-bit FFT index and 7-bit sample index in the mapper's input format. It ping-pongs between two RAM banks, signals the readout side when a bank is full, and stalls the FFT stream if the next bank has not been released.

## Interface
- `DATA_WIDTH`, 16: bin magnitude width.
- `FFT_SIZE`, 256: bins per input frame. Bins 0..FFT_SIZE/2-1 (128) are stored.
- `FFTS_PER_BANK`, 25: frames per bank (NO_FFTS=50 over 2 banks). Legal range 1..32.
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `capture_en`, in, 1: sampled only at frame start. Low means the whole frame is consumed and discarded.
- `s_valid`, in, 1: FFT bin valid.
- `s_data`, in, DATA_WIDTH: bin magnitude.
- `s_last`, in, 1: last bin of frame.
- `s_ready`, out, 1: sequencer can accept a bin.
- `bank_release`, in, 2: one-hot pulse from readout marking bank 0 or bank 1 free.
- `wr_en`, out, 1: RAM write strobe.
- `wr_data`, out, DATA_WIDTH: data to write.
- `fft_idx`, out, 7: {1'b0, bank, slot[4:0]}. Bit 5 selects the bank, bits 4:0 select the slot.
- `sample_idx`, out, 7: bin number 0..127.
- `bank_full`, out, 2: one-cycle one-hot pulse when a bank completes.
- `frame_err`, out, 1: one-cycle pulse on a frame-length mismatch. Present only with FRAME_CHECK_EN.

## Operation
- Transfer happens when `s_valid && s_ready`. `bin_cnt` counts transfers within a frame.
- States:
  - ACCEPT: bins 0..127 are written.
  - DISCARD: bins 128..FFT_SIZE-1, or a whole frame when `capture_en` was low at frame start, are consumed without writing.
  - STALL: the target bank is busy and `s_ready` is 0.
- Frame end is bin FFT_SIZE-1. On frame end of a captured frame:
  - slot increments.
  - If slot reaches FFTS_PER_BANK: set `busy[bank]`, pulse `bank_full[bank]`, toggle `bank`, reset slot to 0.
- Frame start, meaning the first transfer after reset or after a frame end:
  - If `busy[bank]`, enter STALL.
  - STALL exits to ACCEPT the cycle after `busy[bank]` clears.
- `bank_release[i]` clears `busy[i]`. A release and a set of the same bank in the same cycle resolve to set. A release of a non-busy bank is ignored.
- Discarded frames (capture_en low) do not advance slot.
- Reset values:
  - `wr_en`, `bank_full`, `frame_err`: 0.
  - `wr_data`, `fft_idx`, `sample_idx`: 0.
  - Internal: `bank` 0, slot 0, `busy` 2'b00, state ACCEPT, `bin_cnt` 0.
  - `s_ready`: 0 during reset, 1 in the first cycle after.
- A reset mid-frame abandons the partial frame. The next bin is treated as bin 0 of a new frame in bank 0, slot 0.

## Timing
- `wr_en`, `wr_data`, `fft_idx` and `sample_idx` are registered. Latency is 1 cycle from the accepting edge.
- `wr_en` is high only for transfers in ACCEPT with `bin_cnt` < 128.
- `bank_full` pulses in the cycle after the final bin of the completing frame is accepted. It is coincident with that bin's write if FFT_SIZE = 128.
- `s_ready` is combinational from state and `busy`. It drops in the cycle STALL is entered, so the first bin of a stalled frame is held, not lost.
- Back-to-back frames with no idle cycle are supported. Throughput is 1 bin per clock.

## Configuration
- `FRAME_CHECK_EN` defined:
  - A frame also ends on `s_last`.
  - If `s_last` arrives at a bin other than FFT_SIZE-1, or bin FFT_SIZE-1 arrives without `s_last`, then `frame_err` pulses 1 cycle after that bin and the frame ends there.
  - Slot advances only if all 128 stored bins were written. Otherwise the slot is reused.
- `FRAME_CHECK_EN` undefined:
  - `s_last` is ignored. The frame ends on the bin count only.
  - `frame_err` is tied to 0.

## Test plan
- Reset, then 1 frame of 256 bins with data = bin number, `capture_en`=1 -> 128 writes with `fft_idx`=0, `sample_idx` 0..127 and `wr_data` 0..127; bins 128..255 produce no `wr_en`.
- 25 back-to-back frames -> `bank_full`=2'b01 after frame 25. Frame 26 writes use `fft_idx`=7'd32 (bank 1, slot 0).
- 50 frames with no `bank_release` -> `bank_full`=2'b10 after frame 50. At frame 51 start, `s_ready`=0 holds. Pulse `bank_release`=2'b01 -> frame 51 written with `fft_idx`=0 and no bin lost.
- `capture_en`=0 at the start of frame 2 -> no writes for frame 2. Frame 3 uses slot 1.
- With FRAME_CHECK_EN, `s_last` at bin 99 -> `frame_err` pulse. The next frame rewrites slot 0 from `sample_idx` 0.
- `rst_n` low at bin 60 of slot 3 -> all outputs zero. The next frame writes `fft_idx`=0.

Source files
------------

// File: rtl/fft_bin_write_seq.sv
// Ping-pong write sequencer from the FFT output stream to the spectrogram-RAM mapper.
// Optional FRAME_CHECK_EN: frames also end on s_last, and length mismatches pulse frame_err.
module fft_bin_write_seq #(
  parameter int DATA_WIDTH    = 16,
  parameter int FFT_SIZE      = 256,
  parameter int FFTS_PER_BANK = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture_en,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic [1:0]            bank_release,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [6:0]            fft_idx,
  output logic [6:0]            sample_idx,
  output logic [1:0]            bank_full,
  output logic                  frame_err
);

  localparam int CW   = $clog2(FFT_SIZE);
  localparam int KEEP = 128;

  typedef enum logic [1:0] {
    ACCEPT  = 2'd0,
    DISCARD = 2'd1,
    STALL   = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         bin_cnt, bin_cnt_nx;
  logic [4:0]            slot, slot_nx;
  logic                  bank, bank_nx;
  logic [1:0]            busy, busy_nx;
  logic                  cap, cap_nx;

  logic                  wr_en_nx;
  logic [DATA_WIDTH-1:0] wr_data_nx;
  logic [6:0]            fft_idx_nx;
  logic [6:0]            sample_idx_nx;
  logic [1:0]            bank_full_nx;

  logic                  start;
  logic                  xfer;
  logic                  last_bin;
  logic                  frame_end;
  logic                  cap_now;
  logic                  advance;

  assign start    = (bin_cnt == '0);
  assign last_bin = (bin_cnt == CW'(FFT_SIZE - 1));
  assign cap_now  = start ? capture_en : cap;

  // Ready drops combinationally at a frame boundary whose bank is still busy,
  // so the first bin of that frame is held rather than consumed.
  assign s_ready = rst_n &&
                   (((state == ACCEPT) && !(start && busy[bank])) ||
                    (state == DISCARD));
  assign xfer    = s_valid && s_ready;

`ifdef FRAME_CHECK_EN
  logic err;
  assign err       = xfer && (s_last != last_bin);
  assign frame_end = xfer && (s_last || last_bin);
  assign advance   = cap_now && (bin_cnt >= CW'(KEEP - 1));
`else
  logic unused_last;
  assign unused_last = s_last;
  assign frame_end   = xfer && last_bin;
  assign advance     = cap_now;
`endif

  always_comb begin
    state_nx      = state;
    bin_cnt_nx    = bin_cnt;
    slot_nx       = slot;
    bank_nx       = bank;
    cap_nx        = cap;
    busy_nx       = busy & ~bank_release;
    wr_en_nx      = 1'b0;
    wr_data_nx    = wr_data;
    fft_idx_nx    = fft_idx;
    sample_idx_nx = sample_idx;
    bank_full_nx  = '0;

    case (state)
      STALL: begin
        if (!busy[bank]) state_nx = ACCEPT;
      end
      ACCEPT: begin
        if (start && busy[bank]) begin
          state_nx = STALL;
        end else if (xfer) begin
          if (start) cap_nx = capture_en;
          if (cap_now && (bin_cnt < CW'(KEEP))) begin
            wr_en_nx      = 1'b1;
            wr_data_nx    = s_data;
            fft_idx_nx    = {1'b0, bank, slot};
            sample_idx_nx = bin_cnt[6:0];
            if (bin_cnt == CW'(KEEP - 1)) state_nx = DISCARD;
          end else begin
            state_nx = DISCARD;
          end
        end
      end
      DISCARD: ;
      default: state_nx = ACCEPT;
    endcase

    // A set of the completing bank wins over a same-cycle release of it.
    if (frame_end) begin
      bin_cnt_nx = '0;
      state_nx   = ACCEPT;
      if (advance) begin
        if (slot == 5'(FFTS_PER_BANK - 1)) begin
          slot_nx            = '0;
          bank_nx            = ~bank;
          busy_nx[bank]      = 1'b1;
          bank_full_nx[bank] = 1'b1;
        end else begin
          slot_nx = slot + 5'd1;
        end
      end
    end else if (xfer) begin
      bin_cnt_nx = bin_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACCEPT;
      bin_cnt    <= '0;
      slot       <= '0;
      bank       <= 1'b0;
      busy       <= '0;
      cap        <= 1'b0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      fft_idx    <= '0;
      sample_idx <= '0;
      bank_full  <= '0;
    end else begin
      state      <= state_nx;
      bin_cnt    <= bin_cnt_nx;
      slot       <= slot_nx;
      bank       <= bank_nx;
      busy       <= busy_nx;
      cap        <= cap_nx;
      wr_en      <= wr_en_nx;
      wr_data    <= wr_data_nx;
      fft_idx    <= fft_idx_nx;
      sample_idx <= sample_idx_nx;
      bank_full  <= bank_full_nx;
    end
  end

`ifdef FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= err;
  end
`else
  assign frame_err = 1'b0;
`endif

  a_release_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bank_release));
  a_full_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bank_full));
  a_stall_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
    (state == STALL) |-> !s_ready);

endmodule

// File: tb/tb_fft_bin_write_seq.sv
// Directed self-checking bench for fft_bin_write_seq (default parameters).
module tb_fft_bin_write_seq;

  localparam int DW = 16;
  localparam int FS = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          capture_en;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic [1:0]    bank_release;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [6:0]    fft_idx;
  logic [6:0]    sample_idx;
  logic [1:0]    bank_full;
  logic          frame_err;

  int n_vec = 0;
  int n_bad = 0;
  int last_cycles;

  always #5 clk = ~clk;

  fft_bin_write_seq #(
    .DATA_WIDTH   (DW),
    .FFT_SIZE     (FS),
    .FFTS_PER_BANK(25)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture_en  (capture_en),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .bank_release(bank_release),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .fft_idx     (fft_idx),
    .sample_idx  (sample_idx),
    .bank_full   (bank_full),
    .frame_err   (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_and_check(input string tag);
    rst_n        = 1'b0;
    bank_release = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_wr_en"},      32'(wr_en),      32'd0);
    check({tag, "_wr_data"},    32'(wr_data),    32'd0);
    check({tag, "_fft_idx"},    32'(fft_idx),    32'd0);
    check({tag, "_sample_idx"}, 32'(sample_idx), 32'd0);
    check({tag, "_bank_full"},  32'(bank_full),  32'd0);
    check({tag, "_frame_err"},  32'(frame_err),  32'd0);
    check({tag, "_ready_low"},  32'(s_ready),    32'd0);
    rst_n = 1'b1;
    #1;
    check({tag, "_ready_high"}, 32'(s_ready),    32'd1);
  endtask

  // Streams nbins bins (data = bin number); capture_en is inverted after bin 0
  // to show it only matters at frame start.
  task automatic send_frame(input bit cap, input int nbins, input int last_at,
                            input logic [6:0] exp_fidx, input logic [1:0] exp_bf,
                            input bit exp_ferr, input string tag);
    int nwr = 0;
    int errs = 0;
    int cyc = 0;
    int exp_nwr = 0;
    logic [1:0] bf_seen = 2'bxx;
    logic ferr_seen = 1'bx;
    bit r;
    for (int i = 0; i < nbins; i++) begin
      capture_en = (i == 0) ? cap : !cap;
      s_valid    = 1'b1;
      s_data     = DW'(i);
      s_last     = (i == last_at);
      r = 1'b0;
      for (int w = 0; w < 64 && !r; w++) begin
        @(negedge clk);
        r = s_ready;
        @(posedge clk);
        #1;
        cyc++;
      end
      if (!r) begin
        check({tag, "_ready_timeout"}, 32'd0, 32'd1);
        break;
      end
      if (cap && i < 128) begin
        exp_nwr++;
        if (wr_en !== 1'b1 || wr_data !== DW'(i) || sample_idx !== 7'(i) || fft_idx !== exp_fidx)
          errs++;
      end else if (wr_en !== 1'b0) begin
        errs++;
      end
      if (wr_en === 1'b1) nwr++;
      if (i == nbins - 1) begin
        bf_seen   = bank_full;
        ferr_seen = frame_err;
      end else if (bank_full !== 2'b00 || frame_err !== 1'b0) begin
        errs++;
      end
    end
    last_cycles = cyc;
    check({tag, "_fields"},    32'(errs),      32'd0);
    check({tag, "_nwr"},       32'(nwr),       32'(exp_nwr));
    check({tag, "_bank_full"}, 32'(bf_seen),   32'(exp_bf));
    check({tag, "_frame_err"}, 32'(ferr_seen), 32'(exp_ferr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    capture_en   = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    s_last       = 1'b0;
    bank_release = 2'b00;
    reset_and_check("por");

    send_frame(1'b1, FS, FS - 1, 7'd0, 2'b00, 1'b0, "f0");
    check("f0_cycles", 32'(last_cycles), 32'd256);
    send_frame(1'b0, FS, FS - 1, 7'd0, 2'b00, 1'b0, "f1_discard");
    for (int s = 1; s < 25; s++)
      send_frame(1'b1, FS, FS - 1, 7'(s), (s == 24) ? 2'b01 : 2'b00, 1'b0, "bank0");
    for (int s = 0; s < 25; s++)
      send_frame(1'b1, FS, FS - 1, 7'(32 + s), (s == 24) ? 2'b10 : 2'b00, 1'b0, "bank1");

    capture_en = 1'b1;
    s_valid    = 1'b1;
    s_data     = '0;
    s_last     = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("stall_ready", 32'(s_ready), 32'd0);
      check("stall_wr_en", 32'(wr_en),   32'd0);
    end
    @(posedge clk);
    #1 bank_release = 2'b01;
    @(posedge clk);
    #1 bank_release = 2'b00;
    send_frame(1'b1, FS, FS - 1, 7'd0, 2'b00, 1'b0, "f51");
    send_frame(1'b1, FS, FS - 1, 7'd1, 2'b00, 1'b0, "f52");
    send_frame(1'b1, FS, FS - 1, 7'd2, 2'b00, 1'b0, "f53");

    send_frame(1'b1, 60, -1, 7'd3, 2'b00, 1'b0, "slot3_part");
    s_data = DW'(60);
    reset_and_check("midframe");
    send_frame(1'b1, FS, FS - 1, 7'd0, 2'b00, 1'b0, "post_rst");
`ifdef FRAME_CHECK_EN
    send_frame(1'b1, 100, 99, 7'd1, 2'b00, 1'b1, "early_last");
    send_frame(1'b1, FS, FS - 1, 7'd1, 2'b00, 1'b0, "after_err");
    send_frame(1'b1, FS, -1, 7'd2, 2'b00, 1'b1, "no_last");
    send_frame(1'b1, FS, FS - 1, 7'd3, 2'b00, 1'b0, "after_nolast");
`else
    send_frame(1'b1, FS, 99, 7'd1, 2'b00, 1'b0, "last_ignored");
    send_frame(1'b1, FS, FS - 1, 7'd2, 2'b00, 1'b0, "after_ignored");
`endif

    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
